csc_frame_ctrl: RTL and testbench
=================================

// Module: csc_frame_ctrl
// PURPOSE
//  Frame-level sequencer in front of the YCbCr->RGB converter. It arms on a software start and
//  aligns to the next frame boundary. It then forwards a programmed number of frames to the
//  converter and gates the pixel stream off cleanly between runs. Per-frame line/pixel counts
//  are checked and reported as sticky errors.
// PARAMETERS
//  H_ACTIVE     1280  expected valid pixels per line
//  V_ACTIVE     720   expected lines per frame
//  CSC_LATENCY  2     downstream converter latency in cycles (length of drain)
//  FRAME_CNT_W  16    width of frame_cnt
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   one clock; reset is synchronous and active-low
//  cfg_start    in   1   pulse: arm a run
//  cfg_stop     in   1   pulse: end run at next frame boundary
//  cfg_frames   in   8   frames per run, latched on accepted start; 0 = continuous
//  in_valid     in   1   upstream pixel valid
//  in_hs/in_vs  in   1   upstream syncs, active high
//  in_y/cb/cr   in   8   upstream pixel components
//  csc_valid    out  1   gated valid to converter
//  csc_hs/vs    out  1   syncs to converter
//  csc_y/cb/cr  out  8   pixel components to converter
//  ctrl_busy    out  1   high in ARMED, ACTIVE or DRAIN
//  ctrl_state   out  2   0 IDLE, 1 ARMED, 2 ACTIVE, 3 DRAIN
//  frame_done   out  1   1-cycle pulse per completed forwarded frame
//  frame_cnt    out  FRAME_CNT_W  completed frames since last accepted start; wraps
//  err_hsize    out  1   sticky: a line had pixel count != H_ACTIVE
//  err_vsize    out  1   sticky: a frame had line count != V_ACTIVE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0. Reset mid-frame aborts at once; no drain.
//  - Datapath: one register stage. csc_hs/vs/y/cb/cr = inputs delayed 1 cycle, always.
//  - csc_valid is in_valid delayed 1 cycle, ANDed with (state==ACTIVE) as sampled on the same edge.
//  - Edges use the registered copy: vs_rise = in_vs & ~vs_q; line_end = ~in_valid & valid_q.
//  - FSM:
//    - IDLE -> ARMED on cfg_start.
//      - Accepting a start latches cfg_frames, clears frame_cnt and both errors.
//    - ARMED -> ACTIVE on vs_rise, or -> IDLE on cfg_stop.
//      - The vs_rise cycle's pixel is not forwarded; forwarding starts the cycle after.
//    - ACTIVE: count pixels while in_valid.
//      - On line_end: err_hsize |= (pix_cnt != H_ACTIVE); line_cnt++; pix_cnt <= 0.
//      - On vs_rise (frame end):
//        - err_vsize |= (line_cnt != V_ACTIVE); frame_done pulse; frame_cnt++; line_cnt <= 0.
//        - Go to DRAIN if stop is pending, or if cfg_frames != 0 and frame_cnt+1 == cfg_frames.
//        - Otherwise stay ACTIVE; the same edge starts the next frame.
//    - DRAIN: csc_valid forced 0; hold CSC_LATENCY cycles so the converter flushes, then IDLE.
//  - A vs_rise in ACTIVE before any line_end counts as a frame with 0 lines; it sets err_vsize.
//  - cfg_stop in ACTIVE sets stop_pending; honoured at the next vs_rise. No mid-frame cut.
//  - cfg_stop in IDLE or DRAIN is ignored; cfg_start outside IDLE is ignored.
//  - Simultaneous cfg_start and cfg_stop in IDLE: stop wins, state stays IDLE.
//  - line_end and vs_rise in the same cycle: close the line first (its checks and line_cnt++).
//    Then close the frame using the updated line_cnt.
//  - pix_cnt and line_cnt saturate at all-ones; no wrap, so oversize is always detected.
//  - Counter widths: $clog2(H_ACTIVE+2) and $clog2(V_ACTIVE+2).
//  - frame_cnt wraps modulo 2^FRAME_CNT_W. The run-length compare uses a separate 8-bit counter.
// STRUCTURE
//  - Shared package csc_ctrl_pkg: state encoding (IDLE/ARMED/ACTIVE/DRAIN) and default timing constants.
//  - One sub-module csc_timing_check: edge detect, pix/line counters, size compares.
//    It outputs line_end, vs_rise, hsize_bad and vsize_bad strobes.
//  - FSM, gating and output registers stay in csc_frame_ctrl.
// TESTING  (bench uses H_ACTIVE=8, V_ACTIVE=4, CSC_LATENCY=2)
//  - Reset hold: reset_n=0 for 3 clks with random inputs -> every output 0, ctrl_state=0.
//  - Start with cfg_frames=2, 3 clean frames sent:
//    - ARMED until first vs_rise, csc_valid 0 before it.
//    - Exactly 64 csc_valid cycles forwarded; frame_done pulses twice; frame_cnt=2.
//    - 2 DRAIN cycles, then IDLE; no errors.
//  - cfg_frames=0, cfg_stop mid-frame 3 -> frame 3 forwarded complete; DRAIN at next vs_rise; frame_cnt=3.
//  - Line of 7 pixels in frame 1 -> err_hsize=1 from cycle after that line_end.
//    - err_hsize stays set through IDLE; the next accepted start clears it.
//  - Frame of 5 lines -> err_vsize=1 at its vs_rise.
//    - Frame of 3 lines with line_end coincident with vs_rise -> err_vsize=1.
//  - cfg_start+cfg_stop same cycle in IDLE -> stays IDLE.
//    - reset_n low mid-frame in ACTIVE -> csc_valid 0 next clk, state IDLE, no drain.

Source files
------------

// File: rtl/csc_ctrl_pkg.sv
// Shared definitions for the YCbCr->RGB frame sequencer: state encoding and default timing.
package csc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } ctrl_state_e;

    localparam int unsigned DEF_H_ACTIVE    = 1280;
    localparam int unsigned DEF_V_ACTIVE    = 720;
    localparam int unsigned DEF_CSC_LATENCY = 2;
    localparam int unsigned DEF_FRAME_CNT_W = 16;
    localparam int unsigned RUN_CNT_W       = 8;

endpackage

// File: rtl/csc_timing_check.sv
// Sync edge detection plus saturating pixel/line counters that flag lines and frames of the wrong size.
module csc_timing_check
    import csc_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic in_valid,
    input  logic in_vs,
    output logic line_end,
    output logic vs_rise,
    output logic hsize_bad,
    output logic vsize_bad
);

    localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 2);
    localparam int unsigned LINE_W = $clog2(V_ACTIVE + 2);

    logic              valid_q;
    logic              vs_q;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_W-1:0] line_cnt_upd;

    always_comb begin
        vs_rise  = in_vs & ~vs_q;
        line_end = ~in_valid & valid_q;

        // A line closing on the frame-end edge is counted before the frame check.
        line_cnt_upd = line_cnt_q;
        if (line_end && line_cnt_q != '1) begin
            line_cnt_upd = line_cnt_q + LINE_W'(1);
        end

        hsize_bad = active & line_end & (pix_cnt_q != PIX_W'(H_ACTIVE));
        vsize_bad = active & vs_rise & (line_cnt_upd != LINE_W'(V_ACTIVE));

        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_upd;
        if (!active) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end else begin
            if (line_end) begin
                pix_cnt_d = '0;
            end else if (in_valid && pix_cnt_q != '1) begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
            if (vs_rise) begin
                line_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            vs_q       <= 1'b0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            valid_q    <= in_valid;
            vs_q       <= in_vs;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

endmodule

// File: rtl/csc_frame_ctrl.sv
// Frame-level sequencer ahead of the colour-space converter: arms on start, forwards N frames
// aligned to vsync, drains the converter pipeline, and reports sticky size errors.
module csc_frame_ctrl
    import csc_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned CSC_LATENCY = DEF_CSC_LATENCY,
    parameter int unsigned FRAME_CNT_W = DEF_FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [7:0]             cfg_frames,
    input  logic                   in_valid,
    input  logic                   in_hs,
    input  logic                   in_vs,
    input  logic [7:0]             in_y,
    input  logic [7:0]             in_cb,
    input  logic [7:0]             in_cr,
    output logic                   csc_valid,
    output logic                   csc_hs,
    output logic                   csc_vs,
    output logic [7:0]             csc_y,
    output logic [7:0]             csc_cb,
    output logic [7:0]             csc_cr,
    output logic                   ctrl_busy,
    output logic [1:0]             ctrl_state,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_hsize,
    output logic                   err_vsize
);

    localparam int unsigned DRAIN_W = (CSC_LATENCY < 2) ? 1 : $clog2(CSC_LATENCY + 1);

    ctrl_state_e            state_q, state_d;
    logic [RUN_CNT_W-1:0]   frames_q, frames_d;
    logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   err_h_q, err_h_d;
    logic                   err_v_q, err_v_d;
    logic                   frame_done_q, frame_done_d;
    logic                   csc_valid_q, csc_valid_d;
    logic                   csc_hs_q, csc_vs_q;
    logic [7:0]             csc_y_q, csc_cb_q, csc_cr_q;

    logic line_end, vs_rise, hsize_bad, vsize_bad;
    logic active;

    assign active = (state_q == ST_ACTIVE);

    csc_timing_check #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .active    (active),
        .in_valid  (in_valid),
        .in_vs     (in_vs),
        .line_end  (line_end),
        .vs_rise   (vs_rise),
        .hsize_bad (hsize_bad),
        .vsize_bad (vsize_bad)
    );

    always_comb begin
        state_d      = state_q;
        frames_d     = frames_q;
        run_cnt_d    = run_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        stop_pend_d  = stop_pend_q;
        err_h_d      = err_h_q;
        err_v_d      = err_v_q;
        frame_done_d = 1'b0;
        csc_valid_d  = in_valid & active;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    state_d     = ST_ARMED;
                    frames_d    = cfg_frames;
                    run_cnt_d   = '0;
                    frame_cnt_d = '0;
                    stop_pend_d = 1'b0;
                    err_h_d     = 1'b0;
                    err_v_d     = 1'b0;
                end
            end
            ST_ARMED: begin
                if (cfg_stop) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cfg_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hsize_bad) begin
                    err_h_d = 1'b1;
                end
                if (vs_rise) begin
                    if (vsize_bad) begin
                        err_v_d = 1'b1;
                    end
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                    run_cnt_d    = run_cnt_q + RUN_CNT_W'(1);
                    if (stop_pend_q || cfg_stop || (frames_q != '0 && run_cnt_d == frames_q)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                        stop_pend_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(CSC_LATENCY - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            frames_q     <= '0;
            run_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            drain_cnt_q  <= '0;
            stop_pend_q  <= 1'b0;
            err_h_q      <= 1'b0;
            err_v_q      <= 1'b0;
            frame_done_q <= 1'b0;
            csc_valid_q  <= 1'b0;
            csc_hs_q     <= 1'b0;
            csc_vs_q     <= 1'b0;
            csc_y_q      <= '0;
            csc_cb_q     <= '0;
            csc_cr_q     <= '0;
        end else begin
            state_q      <= state_d;
            frames_q     <= frames_d;
            run_cnt_q    <= run_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            stop_pend_q  <= stop_pend_d;
            err_h_q      <= err_h_d;
            err_v_q      <= err_v_d;
            frame_done_q <= frame_done_d;
            csc_valid_q  <= csc_valid_d;
            csc_hs_q     <= in_hs;
            csc_vs_q     <= in_vs;
            csc_y_q      <= in_y;
            csc_cb_q     <= in_cb;
            csc_cr_q     <= in_cr;
        end
    end

    assign csc_valid  = csc_valid_q;
    assign csc_hs     = csc_hs_q;
    assign csc_vs     = csc_vs_q;
    assign csc_y      = csc_y_q;
    assign csc_cb     = csc_cb_q;
    assign csc_cr     = csc_cr_q;
    assign ctrl_busy  = (state_q != ST_IDLE);
    assign ctrl_state = state_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_hsize  = err_h_q;
    assign err_vsize  = err_v_q;

endmodule

// File: tb/tb_csc_frame_ctrl.sv
// Scoreboard bench for csc_frame_ctrl: a frame-level model queues expected pixels and frame
// completions, and a negedge monitor checks them as the DUT presents them.
module tb_csc_frame_ctrl;

    localparam int unsigned H   = 8;
    localparam int unsigned V   = 4;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_stop;
    logic [7:0]  cfg_frames;
    logic        in_valid, in_hs, in_vs;
    logic [7:0]  in_y, in_cb, in_cr;
    logic        csc_valid, csc_hs, csc_vs;
    logic [7:0]  csc_y, csc_cb, csc_cr;
    logic        ctrl_busy;
    logic [1:0]  ctrl_state;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_hsize, err_vsize;

    always #5 clk = ~clk;

    csc_frame_ctrl #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .CSC_LATENCY (LAT),
        .FRAME_CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_frames (cfg_frames),
        .in_valid   (in_valid),
        .in_hs      (in_hs),
        .in_vs      (in_vs),
        .in_y       (in_y),
        .in_cb      (in_cb),
        .in_cr      (in_cr),
        .csc_valid  (csc_valid),
        .csc_hs     (csc_hs),
        .csc_vs     (csc_vs),
        .csc_y      (csc_y),
        .csc_cb     (csc_cb),
        .csc_cr     (csc_cr),
        .ctrl_busy  (ctrl_busy),
        .ctrl_state (ctrl_state),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err_hsize  (err_hsize),
        .err_vsize  (err_vsize)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_pix[$];
    int   exp_done[$];
    int   valid_seen = 0;

    // Frame-level reference model state
    logic armed = 1'b0;
    logic fwd = 1'b0;
    logic stop_pend = 1'b0;
    logic exp_eh = 1'b0;
    logic exp_ev = 1'b0;
    int   fwd_done = 0;
    int   cfg_n = 0;
    int   pend_len = -1;

    int   nl[8];
    int   ln[8][8];
    logic coinc[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        return armed ? 1 : (fwd ? 2 : 0);
    endfunction

    always @(negedge clk) begin : monitor
        pix_t e;
        int   d;
        if (csc_valid === 1'b1) begin
            valid_seen++;
            chk("pix_expected", 64'(exp_pix.size() > 0), 64'd1);
            if (exp_pix.size() > 0) begin
                e = exp_pix.pop_front();
                chk("pixel", {csc_hs, csc_vs, csc_y, csc_cb, csc_cr}, e);
            end
        end
        if (frame_done === 1'b1) begin
            chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
            if (exp_done.size() > 0) begin
                d = exp_done.pop_front();
                chk("frame_cnt_at_done", frame_cnt, 64'(d));
            end
        end
    end

    task automatic cyc(input logic v, input logic hs, input logic vs, input logic st, input logic sp);
        pix_t p;
        in_valid  = v;
        in_hs     = hs;
        in_vs     = vs;
        cfg_start = st;
        cfg_stop  = sp;
        in_y      = 8'($urandom);
        in_cb     = 8'($urandom);
        in_cr     = 8'($urandom);
        if (v && fwd && reset_n) begin
            p = {hs, vs, in_y, in_cb, in_cr};
            exp_pix.push_back(p);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_stop();
        if (fwd) stop_pend = 1'b1;
        else if (armed) armed = 1'b0;
    endtask

    task automatic ctl(input logic st, input logic sp, input logic [7:0] n);
        cfg_frames = n;
        if (!armed && !fwd) begin
            if (st && !sp) begin
                armed = 1'b1; cfg_n = n; fwd_done = 0;
                exp_eh = 1'b0; exp_ev = 1'b0; stop_pend = 1'b0;
            end
        end else if (sp) begin
            model_stop();
        end
        cyc(1'b0, 1'b0, 1'b0, st, sp);
        chk("ctl_state", ctrl_state, 64'(exp_state()));
        chk("ctl_err_hsize", err_hsize, exp_eh);
        chk("ctl_err_vsize", err_vsize, exp_ev);
        chk("ctl_frame_cnt", frame_cnt, 64'(fwd_done));
    endtask

    task automatic boundary(input int b);
        logic ended, opening;
        ended = 1'b0;
        opening = armed;
        if (fwd && pend_len >= 0 && pend_len != H) exp_eh = 1'b1;
        pend_len = -1;
        if (fwd && b > 0) begin
            fwd_done++;
            exp_done.push_back(fwd_done);
            if (nl[b-1] != V) exp_ev = 1'b1;
            if (stop_pend || (cfg_n != 0 && fwd_done == cfg_n)) begin
                ended = 1'b1; fwd = 1'b0; stop_pend = 1'b0;
            end
        end
        if (opening) begin
            armed = 1'b0; fwd = 1'b1;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("state_after_vs", ctrl_state, ended ? 64'd3 : 64'(exp_state()));
        chk("err_hsize_vs", err_hsize, exp_eh);
        chk("err_vsize_vs", err_vsize, exp_ev);
        chk("frame_cnt_vs", frame_cnt, 64'(fwd_done));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (ended) begin
            chk("drain_hold", ctrl_state, 64'd3);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_after_drain", {ctrl_busy, ctrl_state}, 64'd0);
        end
    endtask

    task automatic send_frame(input int f, input int stop_l);
        for (int l = 0; l < nl[f]; l++) begin
            for (int i = 0; i < ln[f][l]; i++) begin
                logic sp;
                sp = (l == stop_l && i == 0);
                if (sp) model_stop();
                cyc(1'b1, 1'b0, 1'b0, 1'b0, sp);
            end
            if (coinc[f] && l == nl[f] - 1) begin
                pend_len = fwd ? ln[f][l] : -1;
            end else begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                if (fwd && ln[f][l] != H) exp_eh = 1'b1;
                chk("err_hsize_line", err_hsize, exp_eh);
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic run_stream(input int nf, input int stop_f, input int stop_l);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < nf; f++) begin
            boundary(f);
            send_frame(f, (f == stop_f) ? stop_l : -1);
        end
        boundary(nf);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clean_frames();
        for (int f = 0; f < 8; f++) begin
            nl[f] = V;
            coinc[f] = 1'b0;
            for (int l = 0; l < 8; l++) ln[f][l] = H;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        reset_n = 1'b0;
        cfg_frames = '0;
        for (int i = 0; i < 3; i++) begin
            cfg_start = 1'($urandom); cfg_stop = 1'($urandom); cfg_frames = 8'($urandom);
            in_valid = 1'($urandom); in_hs = 1'($urandom); in_vs = 1'($urandom);
            in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs", {csc_valid, csc_hs, csc_vs, csc_y, csc_cb, csc_cr, ctrl_busy,
                                  ctrl_state, frame_done, frame_cnt, err_hsize, err_vsize}, 64'd0);
        end
        reset_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two-frame run over three clean frames
        clean_frames();
        ctl(1'b1, 1'b0, 8'd2);
        valid_seen = 0;
        run_stream(3, -1, -1);
        chk("valid_count_2frames", 64'(valid_seen), 64'd64);
        chk("frame_cnt_2frames", frame_cnt, 64'd2);

        // Continuous run stopped during the third frame
        clean_frames();
        ctl(1'b1, 1'b0, 8'd0);
        run_stream(4, 2, 1);
        chk("frame_cnt_stop", frame_cnt, 64'd3);

        // Short line in the first frame
        clean_frames();
        ln[0][1] = 7;
        ctl(1'b1, 1'b0, 8'd2);
        run_stream(2, -1, -1);
        chk("err_hsize_held_idle", err_hsize, 64'd1);

        // Start and stop together in IDLE: nothing accepted, errors untouched
        ctl(1'b1, 1'b1, 8'd3);

        // Clean coincident-close frame, then an oversize frame
        clean_frames();
        coinc[0] = 1'b1;
        nl[1] = 5;
        ctl(1'b1, 1'b0, 8'd2);
        run_stream(2, -1, -1);

        // Three-line frame whose last line closes on vsync
        clean_frames();
        nl[0] = 3;
        coinc[0] = 1'b1;
        ctl(1'b1, 1'b0, 8'd1);
        run_stream(1, -1, -1);

        // Stop while armed returns to IDLE
        ctl(1'b1, 1'b0, 8'd1);
        ctl(1'b0, 1'b1, 8'd1);

        // Reset in the middle of an active frame
        clean_frames();
        ctl(1'b1, 1'b0, 8'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        boundary(0);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < H; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        armed = 1'b0; fwd = 1'b0; fwd_done = 0; stop_pend = 1'b0;
        exp_eh = 1'b0; exp_ev = 1'b0; pend_len = -1;
        reset_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset_valid", csc_valid, 64'd0);
        chk("midreset_state", {ctrl_busy, ctrl_state}, 64'd0);
        chk("midreset_frame_cnt", frame_cnt, 64'd0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset_no_drain", ctrl_state, 64'd0);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            int nf, sf, sl, n;
            nf = $urandom_range(2, 4);
            for (int f = 0; f < 8; f++) begin
                nl[f] = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : V;
                coinc[f] = 1'($urandom_range(0, 1));
                for (int l = 0; l < 8; l++)
                    ln[f][l] = ($urandom_range(0, 5) == 0) ? $urandom_range(7, 9) : H;
            end
            n = $urandom_range(0, nf);
            sf = -1;
            sl = -1;
            if (n == 0) begin
                sf = $urandom_range(0, nf - 1);
                sl = $urandom_range(0, nl[sf] - 1);
            end
            ctl(1'b1, 1'b0, 8'(n));
            run_stream(nf, sf, sl);
        end

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pix_queue_empty", 64'(exp_pix.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
